fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of decode. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. It loads the IF/ID pipeline register (instruction, PC, valid) consumed by the decode stage. Load-use stalls from the hazard unit and taken-branch redirects from decode are applied here, including discarding wrong-path fetches still in flight.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_if.sv | 13 +
 rtl/fetch_perf_ctr.sv | 27 ++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its helpers.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    // Instruction fetches are word aligned; the low address bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory req/ack handshake between the fetch stage (master) and memory (slave).
interface fetch_if;
    import fetch_pkg::*;

    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_perf_ctr.sv
// Saturating fetch and stall event counters; only built when FETCH_PERF_CNT_EN is defined.
module fetch_perf_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch_inc_i && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_inc_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake and loads IF/ID.
// Optional perf counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0064
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    fetch_if.master           imem,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [31:0]       id_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    fetch_state_e      state_q;
    logic [31:0]       pc_q;
    logic [31:0]       drain_addr_q;
    logic [INST_W-1:0] hold_q;
    logic              req_q;
    logic              id_valid_q;
    logic [INST_W-1:0] id_inst_q;
    logic [31:0]       id_pc_q;

    logic              load_valid;
    logic [INST_W-1:0] load_inst;
    logic [31:0]       br_pc;

    // A real instruction enters IF/ID either straight from memory or from the holding register.
    assign load_valid = !br_taken && !stall &&
                        (((state_q == REQ) && imem.imem_ack) || (state_q == HOLD));
    assign load_inst  = (state_q == HOLD) ? hold_q : imem.imem_rdata;
    assign br_pc      = align_pc(br_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            hold_q       <= NOP_INST;
            req_q        <= 1'b0;
            id_valid_q   <= 1'b0;
            id_inst_q    <= NOP_INST;
            id_pc_q      <= '0;
        end else if (br_taken) begin
            // NOTE: non-blocking assignments keep every register update in this block order-independent.
            id_valid_q <= 1'b0;
            pc_q       <= br_pc;
            req_q      <= 1'b1;
            case (state_q)
                REQ: begin
                    if (imem.imem_ack) begin
                        state_q <= REQ;
                    end else begin
                        drain_addr_q <= pc_q;
                        state_q      <= DRAIN;
                    end
                end
                DRAIN:   state_q <= DRAIN;
                default: state_q <= REQ;
            endcase
        end else if (load_valid) begin
            id_valid_q <= 1'b1;
            id_inst_q  <= load_inst;
            id_pc_q    <= pc_q;
            pc_q       <= pc_q + PC_STEP;
            state_q    <= REQ;
            req_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    if (imem.imem_ack) begin
                        hold_q  <= imem.imem_rdata;
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                    end else if (!stall) begin
                        id_valid_q <= 1'b0;
                    end
                end
                HOLD: state_q <= HOLD;
                DRAIN: begin
                    // The acked word belongs to the wrong path and is dropped.
                    if (!stall) id_valid_q <= 1'b0;
                    if (imem.imem_ack) state_q <= REQ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign id_valid       = id_valid_q;
    assign id_inst        = id_inst_q;
    assign id_pc          = id_pc_q;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_ctr u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_inc_i (load_valid),
        .stall_inc_i (stall),
        .fetch_cnt_o (fetch_cnt),
        .stall_cnt_o (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus an IF/ID scoreboard.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        ack_drv = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    fetch_if imem_bus ();
    assign imem_bus.imem_ack   = ack_drv;
    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    fetch_stage #(.RESET_PC(32'h0000_0064)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem      (imem_bus),
        .id_valid  (id_valid),
        .id_inst   (id_inst),
        .id_pc     (id_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of IF/ID loads expected on the correct path.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;
    sb_t sb_q[$];

    task automatic push_exp(input logic [31:0] pc);
        sb_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        sb_q.push_back(e);
    endtask

    logic        prev_v  = 1'b0;
    logic [31:0] prev_pc = '0;

    always @(negedge clk) begin
        if (rst_n && id_valid && (!prev_v || id_pc != prev_pc)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_load", 32'(sb_q.size()), 32'd1);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_id_pc", id_pc, e.pc);
                check("sb_id_inst", id_inst, e.inst);
            end
        end
        prev_v  = id_valid;
        prev_pc = id_pc;
    end

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t, input logic a,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.ack = a;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    // Outputs are checked before the edge, then the vector's inputs are applied for that edge.
    task automatic apply_vec(input int i);
        check($sformatf("v%0d_req", i), 32'(imem_bus.imem_req), 32'(vecs[i].exp_req));
        check($sformatf("v%0d_addr", i), imem_bus.imem_addr, vecs[i].exp_addr);
        check($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vecs[i].exp_valid));
        if (vecs[i].exp_valid) check($sformatf("v%0d_pc", i), id_pc, vecs[i].exp_pc);
        stall     = vecs[i].stall;
        br_taken  = vecs[i].br;
        br_target = vecs[i].tgt;
        ack_drv   = vecs[i].ack;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, 32'(imem_bus.imem_req), 32'd0);
        check({tag, "_valid"}, 32'(id_valid), 32'd0);
        check({tag, "_inst"}, id_inst, 32'd0);
        check({tag, "_pc"}, id_pc, 32'd0);
        check({tag, "_addr"}, imem_bus.imem_addr, 32'h0000_0064);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; br_taken = 1'b0; br_target = '0; ack_drv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //              stall br  target        ack  req addr          valid pc
        vecs[0]  = mk(0, 0, 32'h0,         1, 0, 32'h64,        0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,         1, 1, 32'h64,        0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,         1, 1, 32'h68,        1, 32'h64);
        vecs[3]  = mk(0, 0, 32'h0,         1, 1, 32'h6C,        1, 32'h68);
        vecs[4]  = mk(0, 0, 32'h0,         0, 1, 32'h70,        1, 32'h6C);
        vecs[5]  = mk(0, 0, 32'h0,         0, 1, 32'h70,        0, 32'h0);
        vecs[6]  = mk(0, 0, 32'h0,         1, 1, 32'h70,        0, 32'h0);
        vecs[7]  = mk(1, 0, 32'h0,         1, 1, 32'h74,        1, 32'h70);
        vecs[8]  = mk(1, 0, 32'h0,         0, 0, 32'h74,        1, 32'h70);
        vecs[9]  = mk(1, 0, 32'h0,         0, 0, 32'h74,        1, 32'h70);
        vecs[10] = mk(0, 0, 32'h0,         1, 0, 32'h74,        1, 32'h70);
        vecs[11] = mk(0, 1, 32'h200,       1, 1, 32'h78,        1, 32'h74);
        vecs[12] = mk(0, 0, 32'h0,         1, 1, 32'h200,       0, 32'h0);
        vecs[13] = mk(0, 1, 32'h303,       0, 1, 32'h204,       1, 32'h200);
        vecs[14] = mk(0, 0, 32'h0,         0, 1, 32'h204,       0, 32'h0);
        vecs[15] = mk(0, 0, 32'h0,         0, 1, 32'h204,       0, 32'h0);
        vecs[16] = mk(0, 0, 32'h0,         1, 1, 32'h204,       0, 32'h0);
        vecs[17] = mk(0, 0, 32'h0,         1, 1, 32'h300,       0, 32'h0);
        vecs[18] = mk(0, 0, 32'h0,         0, 1, 32'h304,       1, 32'h300);
        vecs[19] = mk(0, 1, 32'hFFFF_FFFF, 1, 1, 32'h304,       0, 32'h0);
        vecs[20] = mk(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0);
        vecs[21] = mk(0, 0, 32'h0,         1, 1, 32'h0,         1, 32'hFFFF_FFFC);
        vecs[22] = mk(1, 0, 32'h0,         0, 1, 32'h4,         1, 32'h0);
        vecs[23] = mk(1, 0, 32'h0,         1, 1, 32'h4,         1, 32'h0);
        vecs[24] = mk(1, 1, 32'h400,       0, 0, 32'h4,         1, 32'h0);
        vecs[25] = mk(0, 0, 32'h0,         1, 1, 32'h400,       0, 32'h0);
        vecs[26] = mk(0, 0, 32'h0,         0, 1, 32'h404,       1, 32'h400);

        // Reset state
        idle_inputs();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // Streaming, wait states, stall/hold, redirects, drain, PC wrap, redirect from HOLD
        foreach (vecs[i]) if (i < 0) $display("unused");
        push_exp(32'h64); push_exp(32'h68); push_exp(32'h6C); push_exp(32'h70);
        push_exp(32'h74); push_exp(32'h200); push_exp(32'h300);
        push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h400);
        rst_n = 1'b1;
        for (int i = 0; i < 27; i++) apply_vec(i);
        check("table_sb_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset away from any clock edge
        ack_drv = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        idle_inputs();
        repeat (2) @(negedge clk);

        // Redirect while IDLE only moves the PC
        rst_n     = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h800;
        @(negedge clk);
        check("idle_br_req", 32'(imem_bus.imem_req), 32'd1);
        check("idle_br_addr", imem_bus.imem_addr, 32'h800);
        check("idle_br_valid", 32'(id_valid), 32'd0);
        push_exp(32'h800);
        br_taken = 1'b0;
        ack_drv  = 1'b1;
        @(negedge clk);
        check("idle_br_load", 32'(id_valid), 32'd1);
        ack_drv = 1'b0;
        @(negedge clk);
        check("idle_br_sb_drained", 32'(sb_q.size()), 32'd0);

`ifdef FETCH_PERF_CNT_EN
        // Ten loads then four stall cycles, then an asynchronous reset clears both counters
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("perf_rst_fetch", fetch_cnt, 32'd0);
        check("perf_rst_stall", stall_cnt, 32'd0);
        rst_n   = 1'b1;
        ack_drv = 1'b1;
        for (int k = 0; k < 10; k++) push_exp(32'h64 + 32'(4 * k));
        @(negedge clk);
        repeat (10) @(negedge clk);
        ack_drv = 1'b0;
        stall   = 1'b1;
        repeat (4) @(negedge clk);
        stall = 1'b0;
        check("perf_fetch_cnt", fetch_cnt, 32'd10);
        check("perf_stall_cnt", stall_cnt, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("perf_async_fetch", fetch_cnt, 32'd0);
        check("perf_async_stall", stall_cnt, 32'd0);
        @(negedge clk);
`endif

        check("final_sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
